// File: rtl/decode_stage_pkg.sv
// -----------------------------------------------------------------------------
// decode_stage_pkg
//   Shared types and constants for the decode stage.
//   - InstructionType : immediate format class of a decoded instruction.
//                       INST_TYPE_I is encoded as 0 so a cleared entry reads
//                       as type I.
//   - OPC_* / F3_*    : RV32I opcode and funct3 constants used by the decoder.
//   - skid_state_e    : occupancy of the main/skid register pair.
//   - decoded_t       : one decoded entry as held in the main or skid register.
//   - funct3_illegal  : funct3 legality check for opcodes with reserved funct3.
// -----------------------------------------------------------------------------
package decode_stage_pkg;

  typedef enum logic [2:0] {
    INST_TYPE_I = 3'd0,
    INST_TYPE_S = 3'd1,
    INST_TYPE_B = 3'd2,
    INST_TYPE_U = 3'd3,
    INST_TYPE_J = 3'd4,
    INST_TYPE_R = 3'd5
  } InstructionType;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Reserved funct3 encodings
  localparam logic [2:0] F3_BRANCH_RSV0 = 3'b010;
  localparam logic [2:0] F3_BRANCH_RSV1 = 3'b011;
  localparam logic [2:0] F3_LOAD_RSV0   = 3'b011;
  localparam logic [2:0] F3_LOAD_RSV1   = 3'b110;
  localparam logic [2:0] F3_LOAD_RSV2   = 3'b111;
  localparam logic [2:0] F3_STORE_MAX   = 3'b010; // SB/SH/SW only
  localparam logic [2:0] F3_JALR        = 3'b000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  typedef struct packed {
    InstructionType inst_type;
    logic [31:0]    imm;
    logic [4:0]     rs1;
    logic [4:0]     rs2;
    logic [4:0]     rd;
    logic [2:0]     funct3;
    logic [6:0]     funct7;
    logic [31:0]    pc;
    logic           illegal;
  } decoded_t;

  localparam decoded_t DECODED_RESET = '0;

  function automatic logic funct3_illegal(input logic [6:0] opcode,
                                          input logic [2:0] funct3);
    logic bad;
    bad = 1'b0;
    case (opcode)
      OPC_BRANCH: bad = (funct3 == F3_BRANCH_RSV0) || (funct3 == F3_BRANCH_RSV1);
      OPC_LOAD:   bad = (funct3 == F3_LOAD_RSV0) || (funct3 == F3_LOAD_RSV1) ||
                        (funct3 == F3_LOAD_RSV2);
      OPC_STORE:  bad = (funct3 > F3_STORE_MAX);
      OPC_JALR:   bad = (funct3 != F3_JALR);
      default:    bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// -----------------------------------------------------------------------------
// ImmGenSubmodule
//   Combinational RV32I immediate generator.
//   Ports:
//     inst_type (in,  InstructionType) format selected by the opcode decoder
//     inst_hi   (in,  25)              instruction bits [31:7]
//     imm       (out, 32)              sign-extended immediate; 0 for R type
// -----------------------------------------------------------------------------
module ImmGenSubmodule
  import decode_stage_pkg::*;
(
  input  InstructionType inst_type,
  input  logic [31:7]    inst_hi,
  output logic [31:0]    imm
);

  always_comb begin
    imm = 32'd0;
    case (inst_type)
      INST_TYPE_I: imm = {{20{inst_hi[31]}}, inst_hi[31:20]};
      INST_TYPE_S: imm = {{20{inst_hi[31]}}, inst_hi[31:25], inst_hi[11:7]};
      INST_TYPE_B: imm = {{19{inst_hi[31]}}, inst_hi[31], inst_hi[7],
                          inst_hi[30:25], inst_hi[11:8], 1'b0};
      INST_TYPE_U: imm = {inst_hi[31:12], 12'd0};
      INST_TYPE_J: imm = {{11{inst_hi[31]}}, inst_hi[31], inst_hi[19:12],
                          inst_hi[20], inst_hi[30:21], 1'b0};
      INST_TYPE_R: imm = 32'd0;
      default:     imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   RV32I decode stage with a two-entry (main + skid) output buffer.
//   Instructions are fully decoded on the input side and the decoded fields
//   are stored, so outputs come straight from the main register.
//
//   Handshake: a transfer happens on a side in any cycle where its valid and
//   ready are both high; valid never depends on ready, inReady is decoded from
//   the registered state only, and a presented entry stays unchanged until it
//   is taken (outValid && outReady).
//
//   Ports:
//     clk, rstN            clock, asynchronous active-low reset
//     inValid/inReady      fetch-side handshake
//     inInst, inPc         raw instruction and its address
//     outValid/outReady    execute-side handshake
//     outInstructionType   immediate format class
//     outImm               sign-extended immediate
//     outRs1/Rs2/Rd        register fields, passed through for every type
//     outFunct3/outFunct7  function fields, passed through for every type
//     outPc                instruction address
//     outIllegal           unsupported encoding (flows as a normal entry)
//     flush                drop all held entries and any same-cycle input
//     dbgState             current buffer occupancy (EMPTY/ONE/TWO)
// -----------------------------------------------------------------------------
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter bit CHECK_FUNCT = 1'b1
) (
  input  logic           clk,
  input  logic           rstN,
  input  logic           inValid,
  output logic           inReady,
  input  logic [31:0]    inInst,
  input  logic [31:0]    inPc,
  output logic           outValid,
  input  logic           outReady,
  output InstructionType outInstructionType,
  output logic [31:0]    outImm,
  output logic [4:0]     outRs1,
  output logic [4:0]     outRs2,
  output logic [4:0]     outRd,
  output logic [2:0]     outFunct3,
  output logic [6:0]     outFunct7,
  output logic [31:0]    outPc,
  output logic           outIllegal,
  input  logic           flush,
  output skid_state_e    dbgState
);

  // ---------------------------------------------------------------------------
  // Input-side decode
  // ---------------------------------------------------------------------------
  logic [6:0]     opcode;
  logic [2:0]     funct3;
  InstructionType dec_type;
  logic           dec_illegal;
  logic [31:0]    dec_imm;
  decoded_t       dec_entry;

  assign opcode = inInst[6:0];
  assign funct3 = inInst[14:12];

  always_comb begin
    dec_type    = INST_TYPE_I;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: dec_type = INST_TYPE_U;
      OPC_JAL:            dec_type = INST_TYPE_J;
      OPC_BRANCH:         dec_type = INST_TYPE_B;
      OPC_STORE:          dec_type = INST_TYPE_S;
      OPC_OP:             dec_type = INST_TYPE_R;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM:
                          dec_type = INST_TYPE_I;
      default: begin
        // Unknown opcode: mark illegal, keep type I
        dec_type    = INST_TYPE_I;
        dec_illegal = 1'b1;
      end
    endcase
    if (CHECK_FUNCT && funct3_illegal(opcode, funct3)) begin
      dec_illegal = 1'b1;
    end
  end

  ImmGenSubmodule u_imm_gen (
    .inst_type (dec_type),
    .inst_hi   (inInst[31:7]),
    .imm       (dec_imm)
  );

  always_comb begin
    dec_entry           = DECODED_RESET;
    dec_entry.inst_type = dec_type;
    dec_entry.imm       = dec_imm;
    dec_entry.rs1       = inInst[19:15];
    dec_entry.rs2       = inInst[24:20];
    dec_entry.rd        = inInst[11:7];
    dec_entry.funct3    = inInst[14:12];
    dec_entry.funct7    = inInst[31:25];
    dec_entry.pc        = inPc;
    dec_entry.illegal   = dec_illegal;
  end

  // ---------------------------------------------------------------------------
  // Main + skid buffer
  // ---------------------------------------------------------------------------
  skid_state_e state_q, state_d;
  decoded_t    main_q, main_d;
  decoded_t    skid_q, skid_d;
  logic        in_xfer;
  logic        out_xfer;

  assign inReady  = (state_q != ST_TWO);
  assign outValid = (state_q != ST_EMPTY);
  assign in_xfer  = inValid && inReady;
  assign out_xfer = outValid && outReady;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Flush wins over everything, including an input offered this cycle.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_d  = dec_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = dec_entry;
          end else if (in_xfer) begin
            // Main is held by a stalled consumer; park the newcomer.
            skid_d  = dec_entry;
            state_d = ST_TWO;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // inReady is low here, so only the output side can move.
          if (out_xfer) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= ST_EMPTY;
      main_q  <= DECODED_RESET;
      skid_q  <= DECODED_RESET;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs come directly from the main register
  // ---------------------------------------------------------------------------
  assign outInstructionType = main_q.inst_type;
  assign outImm             = main_q.imm;
  assign outRs1             = main_q.rs1;
  assign outRs2             = main_q.rs2;
  assign outRd              = main_q.rd;
  assign outFunct3          = main_q.funct3;
  assign outFunct7          = main_q.funct7;
  assign outPc              = main_q.pc;
  assign outIllegal         = main_q.illegal;
  assign dbgState           = state_q;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//   Directed bench for decode_stage. Two instances share all inputs: u_dut
//   with funct3 checking enabled and u_nochk with it disabled.
// -----------------------------------------------------------------------------
module tb_decode_stage;
  import decode_stage_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk  = 1'b0;
  logic rstN = 1'b1;
  always #5 clk = ~clk;

  logic        inValid  = 1'b0;
  logic [31:0] inInst   = 32'd0;
  logic [31:0] inPc     = 32'd0;
  logic        outReady = 1'b0;
  logic        flush    = 1'b0;

  logic           inReady, outValid, outIllegal;
  InstructionType outInstructionType;
  logic [31:0]    outImm, outPc;
  logic [4:0]     outRs1, outRs2, outRd;
  logic [2:0]     outFunct3;
  logic [6:0]     outFunct7;
  skid_state_e    dbgState;

  logic           u1_inReady, u1_outValid, u1_outIllegal;
  InstructionType u1_outInstructionType;
  logic [31:0]    u1_outImm, u1_outPc;
  logic [4:0]     u1_outRs1, u1_outRs2, u1_outRd;
  logic [2:0]     u1_outFunct3;
  logic [6:0]     u1_outFunct7;
  skid_state_e    u1_dbgState;

  decode_stage #(.CHECK_FUNCT(1'b1)) u_dut (
    .clk(clk), .rstN(rstN),
    .inValid(inValid), .inReady(inReady), .inInst(inInst), .inPc(inPc),
    .outValid(outValid), .outReady(outReady),
    .outInstructionType(outInstructionType), .outImm(outImm),
    .outRs1(outRs1), .outRs2(outRs2), .outRd(outRd),
    .outFunct3(outFunct3), .outFunct7(outFunct7), .outPc(outPc),
    .outIllegal(outIllegal), .flush(flush), .dbgState(dbgState)
  );

  decode_stage #(.CHECK_FUNCT(1'b0)) u_nochk (
    .clk(clk), .rstN(rstN),
    .inValid(inValid), .inReady(u1_inReady), .inInst(inInst), .inPc(inPc),
    .outValid(u1_outValid), .outReady(outReady),
    .outInstructionType(u1_outInstructionType), .outImm(u1_outImm),
    .outRs1(u1_outRs1), .outRs2(u1_outRs2), .outRd(u1_outRd),
    .outFunct3(u1_outFunct3), .outFunct7(u1_outFunct7), .outPc(u1_outPc),
    .outIllegal(u1_outIllegal), .flush(flush), .dbgState(u1_dbgState)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and check helper
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks: advance to just after the next rising edge
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction for exactly one edge, then withdraw it.
  task automatic send(input logic [31:0] inst, input logic [31:0] pc);
    inValid = 1'b1;
    inInst  = inst;
    inPc    = pc;
    cyc();
    inValid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    // Reset state
    #2 rstN = 1'b0;
    #1;
    chk("rst_outValid", 32'(outValid), 32'd0);
    chk("rst_inReady",  32'(inReady),  32'd1);
    chk("rst_imm",      outImm,        32'd0);
    chk("rst_type",     32'(outInstructionType), 32'(INST_TYPE_I));
    chk("rst_pc",       outPc,         32'd0);
    chk("rst_state",    32'(dbgState), 32'(ST_EMPTY));
    @(posedge clk);
    @(posedge clk);
    #3 rstN = 1'b1;
    cyc();

    // addi x1,x0,5 : latency 1, type I
    outReady = 1'b1;
    send(32'h0050_0093, 32'h0000_0100);
    chk("addi_valid", 32'(outValid), 32'd1);
    chk("addi_type",  32'(outInstructionType), 32'(INST_TYPE_I));
    chk("addi_imm",   outImm, 32'd5);
    chk("addi_rd",    32'(outRd), 32'd1);
    chk("addi_rs1",   32'(outRs1), 32'd0);
    chk("addi_pc",    outPc, 32'h0000_0100);
    chk("addi_ill",   32'(outIllegal), 32'd0);
    chk("addi_state", 32'(dbgState), 32'(ST_ONE));

    // sw x2,-4(x1) : type S, negative immediate
    send(32'hFE20_AE23, 32'h0000_0104);
    chk("sw_type", 32'(outInstructionType), 32'(INST_TYPE_S));
    chk("sw_imm",  outImm, 32'hFFFF_FFFC);
    chk("sw_rs1",  32'(outRs1), 32'd1);
    chk("sw_rs2",  32'(outRs2), 32'd2);
    chk("sw_f3",   32'(outFunct3), 32'd2);
    chk("sw_ill",  32'(outIllegal), 32'd0);
    chk("sw_pc",   outPc, 32'h0000_0104);
    cyc();
    chk("drain_valid", 32'(outValid), 32'd0);

    // Back-pressure: three offers while execute stalls
    outReady = 1'b0;
    send(32'h0050_0093, 32'h0000_0200);
    chk("bp1_inReady", 32'(inReady), 32'd1);
    chk("bp1_pc",      outPc, 32'h0000_0200);
    send(32'h00A0_0113, 32'h0000_0204);
    chk("bp2_inReady", 32'(inReady), 32'd0);
    chk("bp2_state",   32'(dbgState), 32'(ST_TWO));
    chk("bp2_pc",      outPc, 32'h0000_0200);
    inValid = 1'b1;
    inInst  = 32'h00F0_0193;
    inPc    = 32'h0000_0208;
    cyc();
    chk("bp3_stall_pc",  outPc, 32'h0000_0200);
    chk("bp3_stall_imm", outImm, 32'd5);
    outReady = 1'b1;
    cyc();
    chk("bp_second_pc",  outPc, 32'h0000_0204);
    chk("bp_second_imm", outImm, 32'd10);
    chk("bp_second_rd",  32'(outRd), 32'd2);
    chk("bp_inReady",    32'(inReady), 32'd1);
    cyc();
    inValid = 1'b0;
    chk("bp_third_pc",  outPc, 32'h0000_0208);
    chk("bp_third_imm", outImm, 32'd15);
    chk("bp_third_rd",  32'(outRd), 32'd3);
    cyc();
    chk("bp_drain", 32'(outValid), 32'd0);

    // Other formats and illegal encodings (outReady stays 1)
    send(32'h1234_50B7, 32'h0000_0300);   // lui x1,0x12345
    chk("lui_type", 32'(outInstructionType), 32'(INST_TYPE_U));
    chk("lui_imm",  outImm, 32'h1234_5000);
    send(32'h0080_00EF, 32'h0000_0304);   // jal x1,8
    chk("jal_type", 32'(outInstructionType), 32'(INST_TYPE_J));
    chk("jal_imm",  outImm, 32'd8);
    send(32'h4020_8133, 32'h0000_0308);   // sub x2,x1,x2
    chk("sub_type", 32'(outInstructionType), 32'(INST_TYPE_R));
    chk("sub_imm",  outImm, 32'd0);
    chk("sub_f7",   32'(outFunct7), 32'h20);
    chk("sub_rs2",  32'(outRs2), 32'd2);
    send(32'h0000_007F, 32'h0000_030C);   // unknown opcode
    chk("bad_op_ill",  32'(outIllegal), 32'd1);
    chk("bad_op_type", 32'(outInstructionType), 32'(INST_TYPE_I));
    chk("bad_op_valid", 32'(outValid), 32'd1);
    send(32'h0000_2063, 32'h0000_0310);   // branch funct3=010
    chk("br010_ill_chk",   32'(outIllegal), 32'd1);
    chk("br010_ill_nochk", 32'(u1_outIllegal), 32'd0);
    chk("br010_type",      32'(outInstructionType), 32'(INST_TYPE_B));
    send(32'h0000_10E7, 32'h0000_0314);   // jalr funct3=001
    chk("jalr001_ill", 32'(outIllegal), 32'd1);
    send(32'h0000_3003, 32'h0000_0318);   // load funct3=011
    chk("ld011_ill", 32'(outIllegal), 32'd1);
    send(32'h0000_2003, 32'h0000_031C);   // lw
    chk("lw_ill", 32'(outIllegal), 32'd0);
    cyc();

    // Flush in TWO with a simultaneous offer
    outReady = 1'b0;
    send(32'h0050_0093, 32'h0000_0280);
    send(32'h00A0_0113, 32'h0000_0284);
    chk("fl_state_two", 32'(dbgState), 32'(ST_TWO));
    flush   = 1'b1;
    inValid = 1'b1;
    inInst  = 32'h00F0_0193;
    inPc    = 32'h0000_0300;
    cyc();
    flush   = 1'b0;
    inValid = 1'b0;
    chk("fl_outValid", 32'(outValid), 32'd0);
    chk("fl_inReady",  32'(inReady), 32'd1);
    outReady = 1'b1;
    cyc();
    chk("fl_no_ghost1", 32'(outValid), 32'd0);
    cyc();
    chk("fl_no_ghost2", 32'(outValid), 32'd0);

    // Asynchronous reset mid-cycle while holding one entry
    outReady = 1'b0;
    send(32'h00A0_0113, 32'h0000_0400);
    chk("ar_pre_valid", 32'(outValid), 32'd1);
    #2 rstN = 1'b0;
    #1;
    chk("ar_outValid", 32'(outValid), 32'd0);
    chk("ar_inReady",  32'(inReady), 32'd1);
    chk("ar_imm",      outImm, 32'd0);
    chk("ar_rd",       32'(outRd), 32'd0);
    chk("ar_pc",       outPc, 32'd0);
    chk("ar_type",     32'(outInstructionType), 32'(INST_TYPE_I));
    #3 rstN = 1'b1;
    cyc();
    outReady = 1'b1;
    chk("ar_rel_inReady", 32'(inReady), 32'd1);
    send(32'h00F0_0193, 32'h0000_0404);
    chk("ar_rel_valid", 32'(outValid), 32'd1);
    chk("ar_rel_pc",    outPc, 32'h0000_0404);
    chk("ar_rel_imm",   outImm, 32'd15);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter CHECK_FUNCT, default 1; when 1, funct3 legality checks per REQ-012 are applied.
REQ-002 SHALL have ports clk (in, 1, rising-edge clock) and rstN (in, 1, reset, asynchronous, active-low).
REQ-003 SHALL have input-side ports: inValid (in, 1, fetch offers inst), inReady (out, 1, stage can accept), inInst (in, 32, raw instruction), inPc (in, 32, instruction address).
REQ-004 SHALL have output-side ports: outValid (out, 1, decoded entry present), outReady (in, 1, execute accepts).
REQ-005 SHALL have decoded-output ports: outInstructionType (out, InstructionType), outImm (out, 32, sign-extended immediate), outRs1, outRs2, outRd (out, 5 each), outFunct3 (out, 3), outFunct7 (out, 7), outPc (out, 32), outIllegal (out, 1, unsupported encoding).
REQ-006 SHALL have port flush (in, 1, discard all held entries).

Function
REQ-007 SHALL transfer on the input side when inValid && inReady, and on the output side when outValid && outReady, in the same cycle.
REQ-008 SHALL hold a main register plus one skid register; states EMPTY, ONE, TWO.
REQ-009 SHALL drive inReady = 1 in EMPTY and ONE and 0 in TWO, decoded from registered state only, with no combinational path from outReady.
REQ-010 SHALL apply these transitions:
- EMPTY + in -> ONE.
- ONE + in + out -> ONE.
- ONE + in only -> TWO.
- ONE + out only -> EMPTY.
- TWO + out -> ONE, with the skid entry moving to main.
- All other cases hold state.
REQ-011 SHALL present an accepted instruction on outputs the cycle after acceptance (latency 1); entries leave in acceptance order; outputs stay stable while outValid && !outReady.
REQ-012 SHALL map opcode[6:0] to a type:
- 0110111/0010111 -> U.
- 1101111 -> J.
- 1100011 -> B.
- 0100011 -> S.
- 0110011 -> R.
- 1100111/0000011/0010011/0001111/1110011 -> I.
- Any other opcode -> outIllegal=1 and type I.
- When CHECK_FUNCT=1, these also set outIllegal: BRANCH funct3 010/011, LOAD funct3 011/110/111, STORE funct3 >= 011, JALR funct3 != 000.
REQ-013 SHALL compute outImm via ImmGenSubmodule with the mapped type; R type yields outImm = 0.
REQ-014 SHALL decode before registering, storing decoded fields in main/skid (no decode on the output path).
REQ-015 SHALL pass outRs1/outRs2/outRd/outFunct3/outFunct7 through from bits [19:15]/[24:20]/[11:7]/[14:12]/[31:25] regardless of type.
REQ-016 SHALL give flush priority: the next state is EMPTY, any same-cycle input transfer is dropped, and outValid=0 on the next cycle.
REQ-017 SHALL not flag an illegal instruction as an exception; it flows as a normal entry with outIllegal=1.

Reset
REQ-018 SHALL on rstN low immediately set state EMPTY, outValid=0, inReady=1, and all data registers (imm, fields, pc, type=INST_TYPE_I, illegal) to 0.
REQ-019 SHALL discard in-flight entries when reset is asserted mid-operation; the first cycle after release accepts new input.

Structure
REQ-020 SHALL take InstructionType (including INST_TYPE_R) and opcode/funct3 constants from the shared package typedefs.
REQ-021 SHALL instantiate exactly one ImmGenSubmodule in front of the storage registers; the skid logic stays in decode_stage.

Verification
REQ-022 SHALL show: inInst=0x00500093 (addi x1,x0,5), inPc=0x100, outReady=1 -> next cycle outValid=1, type I, outImm=5, outRd=1, outRs1=0, outPc=0x100.
REQ-023 SHALL show: inInst=0xFE20AE23 (sw x2,-4(x1)) -> type S, outImm=0xFFFFFFFC, outRs1=1, outRs2=2, outIllegal=0.
REQ-024 SHALL show: outReady=0 while 3 consecutive instructions are offered -> inReady drops after the 2nd; with outReady=1 afterwards, the 1st and 2nd emerge in order, then the 3rd is accepted.
REQ-025 SHALL show: inInst=0x0000007F -> outIllegal=1; inInst=0x00002063 (BRANCH funct3=010) with CHECK_FUNCT=1 -> outIllegal=1, and with CHECK_FUNCT=0 -> 0.
REQ-026 SHALL show: in state TWO, assert flush together with inValid=1 -> next cycle outValid=0, inReady=1, and the offered instruction never appears.
REQ-027 SHALL show: rstN pulsed low asynchronously mid-cycle while in ONE -> outValid falls without a clock edge and decoded outputs read 0.
